// File: rtl/axi4_lite_ctrl_slave.sv
// AXI4-Lite control slave: bridges AXI4-Lite writes/reads onto a 4-word
// register file and sequences a one-shot datapath operation from the
// control register.
//
// Ports
//   ACLK, ARSTn              clock, asynchronous active-low reset
//   AW*/W*/B*                AXI4-Lite write address/data/response channels
//   AR*/R*                   AXI4-Lite read address/data channels
//   o_en_amba_write          one-cycle register-file write strobe
//   o_addr_wc/o_data_wc/o_strb  register-file write address/data/strobe
//   o_addr_rc, i_data_rc     register-file read address / combinational data
//   i_start, i_op            control register bit0 / bit1
//   o_is_busy, o_op          operation in flight / latched op select
//   o_en_ctrl_write          result-write strobe
//   o_rst_start              clear-start pulse back to the control register
//
// Build option
//   AXIL_BUSY_STALL_EN       when defined, AWREADY is held low while busy
module axi4_lite_ctrl_slave #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic              AWVALID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  output logic              AWREADY,
  input  logic              WVALID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  output logic              WREADY,
  output logic              BVALID,
  output logic [1:0]        BRESP,
  input  logic              BREADY,
  input  logic              ARVALID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              ARREADY,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  input  logic              RREADY,
  output logic              o_en_amba_write,
  output logic [ADDR_W-1:0] o_addr_wc,
  output logic [DATA_W-1:0] o_data_wc,
  output logic [3:0]        o_strb,
  output logic [ADDR_W-1:0] o_addr_rc,
  input  logic [DATA_W-1:0] i_data_rc,
  input  logic              i_start,
  input  logic              i_op,
  output logic              o_is_busy,
  output logic              o_op,
  output logic              o_en_ctrl_write,
  output logic              o_rst_start
);

  localparam int unsigned NUM_REGS = 4;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_EXEC = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Protection attributes carry no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  logic [1:0]        w_state_q, w_state_d;
  logic [ADDR_W-1:0] addr_wc_q, addr_wc_d;
  logic [DATA_W-1:0] data_wc_q, data_wc_d;
  logic [3:0]        strb_q, strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              en_amba_q, en_amba_d;

  logic [1:0]        r_state_q, r_state_d;
  logic [ADDR_W-1:0] addr_rc_q, addr_rc_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [1:0]        c_state_q, c_state_d;
  logic              busy_q, busy_d;
  logic              op_q, op_d;
  logic              en_ctrl_q, en_ctrl_d;
  logic              rst_start_q, rst_start_d;

  logic              awready_c;
  logic              wr_addr_ok_c;
  logic              rd_addr_ok_c;

  // Ready flags decode registered state only.
`ifdef AXIL_BUSY_STALL_EN
  assign awready_c = (w_state_q == W_IDLE) && !busy_q;
`else
  assign awready_c = (w_state_q == W_IDLE);
`endif

  assign wr_addr_ok_c = (addr_wc_q < ADDR_W'(NUM_REGS));
  assign rd_addr_ok_c = (addr_rc_q < ADDR_W'(NUM_REGS));

  // Write channel: address first, then data, then held response.
  always_comb begin
    w_state_d = w_state_q;
    addr_wc_d = addr_wc_q;
    data_wc_d = data_wc_q;
    strb_d    = strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    en_amba_d = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready_c) begin
          addr_wc_d = AWADDR;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID) begin
          data_wc_d = WDATA;
          strb_d    = WSTRB;
          bvalid_d  = 1'b1;
          bresp_d   = wr_addr_ok_c ? RESP_OKAY : RESP_SLVERR;
          en_amba_d = wr_addr_ok_c;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      w_state_q <= W_IDLE;
      addr_wc_q <= '0;
      data_wc_q <= '0;
      strb_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      en_amba_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      addr_wc_q <= addr_wc_d;
      data_wc_q <= data_wc_d;
      strb_q    <= strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      en_amba_q <= en_amba_d;
    end
  end

  // Read channel: one cycle for the register file to present data.
  always_comb begin
    r_state_d = r_state_q;
    addr_rc_d = addr_rc_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          addr_rc_d = ARADDR;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        rdata_d   = rd_addr_ok_c ? i_data_rc : '0;
        rresp_d   = rd_addr_ok_c ? RESP_OKAY : RESP_SLVERR;
        rvalid_d  = 1'b1;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      r_state_q <= R_IDLE;
      addr_rc_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      addr_rc_q <= addr_rc_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Control sequencer: start -> one exec cycle with strobes -> one done cycle.
  always_comb begin
    c_state_d   = c_state_q;
    op_d        = op_q;
    busy_d      = 1'b0;
    en_ctrl_d   = 1'b0;
    rst_start_d = 1'b0;
    case (c_state_q)
      C_IDLE: begin
        if (i_start) begin
          op_d        = i_op;
          busy_d      = 1'b1;
          en_ctrl_d   = 1'b1;
          rst_start_d = 1'b1;
          c_state_d   = C_EXEC;
        end
      end
      C_EXEC: begin
        busy_d    = 1'b1;
        c_state_d = C_DONE;
      end
      C_DONE: begin
        c_state_d = C_IDLE;
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      c_state_q   <= C_IDLE;
      op_q        <= 1'b0;
      busy_q      <= 1'b0;
      en_ctrl_q   <= 1'b0;
      rst_start_q <= 1'b0;
    end else begin
      c_state_q   <= c_state_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      en_ctrl_q   <= en_ctrl_d;
      rst_start_q <= rst_start_d;
    end
  end

  assign AWREADY         = awready_c;
  assign WREADY          = (w_state_q == W_DATA);
  assign BVALID          = bvalid_q;
  assign BRESP           = bresp_q;
  assign ARREADY         = (r_state_q == R_IDLE);
  assign RVALID          = rvalid_q;
  assign RDATA           = rdata_q;
  assign RRESP           = rresp_q;
  assign o_en_amba_write = en_amba_q;
  assign o_addr_wc       = addr_wc_q;
  assign o_data_wc       = data_wc_q;
  assign o_strb          = strb_q;
  assign o_addr_rc       = addr_rc_q;
  assign o_is_busy       = busy_q;
  assign o_op            = op_q;
  assign o_en_ctrl_write = en_ctrl_q;
  assign o_rst_start     = rst_start_q;

endmodule

// File: tb/tb_axi4_lite_ctrl_slave.sv
// Directed bench for axi4_lite_ctrl_slave with a small register-file/adder
// model attached to the register-file side.
module tb_axi4_lite_ctrl_slave;

  logic        ACLK = 1'b0;
  logic        ARSTn;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        o_en_amba_write;
  logic [31:0] o_addr_wc, o_data_wc, o_addr_rc, i_data_rc;
  logic [3:0]  o_strb;
  logic        i_start, i_op;
  logic        o_is_busy, o_op, o_en_ctrl_write, o_rst_start;

  int n_checks = 0;
  int n_pass   = 0;
  int amba_cnt = 0;
  int ctrl_cnt = 0;
  int rsts_cnt = 0;
  int busy_cnt = 0;

  logic [31:0] rf [4];

  axi4_lite_ctrl_slave #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(3'b000), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(3'b000), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .o_en_amba_write(o_en_amba_write), .o_addr_wc(o_addr_wc),
    .o_data_wc(o_data_wc), .o_strb(o_strb), .o_addr_rc(o_addr_rc),
    .i_data_rc(i_data_rc), .i_start(i_start), .i_op(i_op),
    .o_is_busy(o_is_busy), .o_op(o_op), .o_en_ctrl_write(o_en_ctrl_write),
    .o_rst_start(o_rst_start)
  );

  always #5 ACLK = ~ACLK;

  // Register file: r0, r1, r2 (result), r3 control; op=1 adds, op=0 xors.
  always @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      for (int i = 0; i < 4; i++) rf[i] <= 32'h0;
    end else begin
      if (o_en_amba_write) begin
        for (int b = 0; b < 4; b++)
          if (o_strb[b]) rf[o_addr_wc[1:0]][8*b +: 8] <= o_data_wc[8*b +: 8];
      end
      if (o_en_ctrl_write) rf[2] <= o_op ? (rf[0] + rf[1]) : (rf[0] ^ rf[1]);
      if (o_rst_start) rf[3][0] <= 1'b0;
    end
  end

  assign i_start   = rf[3][0];
  assign i_op      = rf[3][1];
  assign i_data_rc = rf[o_addr_rc[1:0]];

  // Pulse-width counters: one count per cycle the signal is high.
  always @(negedge ACLK) begin
    if (o_en_amba_write) amba_cnt++;
    if (o_en_ctrl_write) ctrl_cnt++;
    if (o_rst_start)     rsts_cnt++;
    if (o_is_busy)       busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold,
                           output logic [1:0] resp);
    int t;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = addr;
    t = 0;
    while (!AWREADY && t < 20) begin @(negedge ACLK); t++; end
    check("aw_ready", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = data; WSTRB = strb;
    t = 0;
    while (!WREADY && t < 20) begin @(negedge ACLK); t++; end
    check("w_ready", 32'(WREADY), 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0;
    t = 0;
    while (!BVALID && t < 20) begin @(negedge ACLK); t++; end
    check("b_valid", 32'(BVALID), 32'd1);
    resp = BRESP;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("b_hold_valid", 32'(BVALID), 32'd1);
      check("b_hold_resp", 32'(BRESP), 32'(resp));
      check("b_hold_awready", 32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_clear", 32'(BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int t;
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = addr;
    t = 0;
    while (!ARREADY && t < 20) begin @(negedge ACLK); t++; end
    check("ar_ready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < 20) begin @(negedge ACLK); t++; end
    check("r_valid", 32'(RVALID), 32'd1);
    data = RDATA;
    resp = RRESP;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("r_hold_valid", 32'(RVALID), 32'd1);
      check("r_hold_data", RDATA, data);
      check("r_hold_resp", 32'(RRESP), 32'(resp));
      check("r_hold_arready", 32'(ARREADY), 32'd0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("r_clear", 32'(RVALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          t;

    ARSTn = 1'b0;
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0;
    BREADY = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;

    // Reset values.
    repeat (2) @(negedge ACLK);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bresp", 32'(BRESP), 32'd0);
    check("rst_rresp", 32'(RRESP), 32'd0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_busy", 32'(o_is_busy), 32'd0);
    check("rst_op", 32'(o_op), 32'd0);
    check("rst_amba", 32'(o_en_amba_write), 32'd0);
    check("rst_addr_wc", o_addr_wc, 32'h0);
    ARSTn = 1'b1;
    @(negedge ACLK);
    check("post_rst_awready", 32'(AWREADY), 32'd1);
    check("post_rst_arready", 32'(ARREADY), 32'd1);

    // Plain write to r0.
    axi_write(32'd0, 32'h0000_aaaa, 4'hf, 0, resp);
    check("w0_bresp", 32'(resp), 32'd0);
    check("w0_amba_cnt", 32'(amba_cnt), 32'd1);
    check("w0_addr_wc", o_addr_wc, 32'd0);
    check("w0_data_wc", o_data_wc, 32'h0000_aaaa);
    check("w0_strb", 32'(o_strb), 32'hf);

    // Write r1 with a stalled response.
    axi_write(32'd1, 32'hbbbb_0000, 4'hf, 5, resp);
    check("w1_bresp", 32'(resp), 32'd0);
    check("w1_amba_cnt", 32'(amba_cnt), 32'd2);

    // Start an add through the control register.
    axi_write(32'd3, 32'h0000_0003, 4'hf, 0, resp);
    check("wc_bresp", 32'(resp), 32'd0);
    repeat (6) @(negedge ACLK);
    check("ctrl_op", 32'(o_op), 32'd1);
    check("ctrl_busy_cycles", 32'(busy_cnt), 32'd2);
    check("ctrl_en_cycles", 32'(ctrl_cnt), 32'd1);
    check("ctrl_rst_start_cycles", 32'(rsts_cnt), 32'd1);
    check("ctrl_busy_now", 32'(o_is_busy), 32'd0);
    check("wc_amba_cnt", 32'(amba_cnt), 32'd3);

    // Result readback with a stalled read response.
    axi_read(32'd2, 5, rdata, resp);
    check("r2_data", rdata, 32'hbbbb_aaaa);
    check("r2_resp", 32'(resp), 32'd0);

    // Invalid addresses.
    axi_write(32'd5, 32'h1234_5678, 4'hf, 0, resp);
    check("w5_bresp", 32'(resp), 32'd2);
    check("w5_no_amba", 32'(amba_cnt), 32'd3);
    axi_read(32'd7, 0, rdata, resp);
    check("r7_data", rdata, 32'h0);
    check("r7_resp", 32'(resp), 32'd2);
    axi_read(32'd0, 0, rdata, resp);
    check("r0_data", rdata, 32'h0000_aaaa);

    // Reset while waiting for write data.
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'd1;
    t = 0;
    while (!AWREADY && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("mid_wready", 32'(WREADY), 32'd1);
    ARSTn = 1'b0;
    #1;
    check("mid_rst_wready", 32'(WREADY), 32'd0);
    check("mid_rst_bvalid", 32'(BVALID), 32'd0);
    check("mid_rst_op", 32'(o_op), 32'd0);
    repeat (2) @(negedge ACLK);
    ARSTn = 1'b1;
    @(negedge ACLK);
    check("mid_no_amba", 32'(amba_cnt), 32'd3);
    check("mid_awready", 32'(AWREADY), 32'd1);

    // Partial-strobe write after recovery; register model was cleared.
    axi_write(32'd1, 32'hdead_beef, 4'h3, 0, resp);
    check("rec_bresp", 32'(resp), 32'd0);
    check("rec_strb", 32'(o_strb), 32'h3);
    check("rec_amba_cnt", 32'(amba_cnt), 32'd4);
    axi_read(32'd1, 0, rdata, resp);
    check("rec_r1_data", rdata, 32'h0000_beef);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_ctrl_slave.md
AXI4_LITE_CTRL_SLAVE -- requirements
Module: axi4_lite_ctrl_slave

Interface
REQ-001 ADDR_W, 32, AXI and register-file address width.
REQ-002 DATA_W, 32, AXI and register-file data width.
REQ-003 ACLK  in  1  single clock; all state on rising edge.
REQ-004 ARSTn  in  1  reset, asynchronous, active-low.
REQ-005 AWVALID in 1, AWADDR in ADDR_W, AWPROT in 3 (ignored), AWREADY out 1: write-address channel.
REQ-006 WVALID in 1, WDATA in DATA_W, WSTRB in 4, WREADY out 1: write-data channel.
REQ-007 BVALID out 1, BRESP out 2, BREADY in 1: write-response channel.
REQ-008 ARVALID in 1, ARADDR in ADDR_W, ARPROT in 3 (ignored), ARREADY out 1: read-address channel.
REQ-009 RVALID out 1, RDATA out DATA_W, RRESP out 2, RREADY in 1: read-data channel.
REQ-010 o_en_amba_write  out  1  one-cycle register-file write strobe.
REQ-011 o_addr_wc out ADDR_W, o_data_wc out DATA_W, o_strb out 4: register-file write address, data and strobe.
REQ-012 o_addr_rc out ADDR_W register-file read address; i_data_rc in DATA_W combinational read data.
REQ-013 i_start  in  1  control-register bit0; i_op  in  1  control-register bit1.
REQ-014 o_is_busy out 1, o_op out 1 datapath op select, o_en_ctrl_write out 1 result-write strobe, o_rst_start out 1 clear-start pulse.

Function
REQ-015 Register map SHALL be word-indexed (not byte-addressed): 0=r0, 1=r1, 2=r2 result, 3=ctrl {bit1 op, bit0 start}; any address >3 is invalid.
REQ-016 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-017 W_IDLE: AWREADY=1; on an AW handshake, latch AWADDR into o_addr_wc and go to W_DATA.
REQ-018 W_DATA: WREADY=1; WVALID before the AW handshake is not accepted, because ordering is address-first.
REQ-019 W_DATA, on a W handshake: latch WDATA into o_data_wc and WSTRB into o_strb; set BVALID=1; set BRESP=00 (valid address) or 10 (invalid address); go to W_RESP.
REQ-020 o_en_amba_write SHALL be high for exactly the cycle after the W handshake, and only for a valid address.
REQ-021 W_RESP: BVALID and BRESP SHALL be held stable until BREADY is sampled high; then BVALID=0 and the FSM returns to W_IDLE.
REQ-022 Read FSM SHALL have states R_IDLE, R_ADDR and R_RESP.
REQ-023 R_IDLE: ARREADY=1; on an AR handshake, latch ARADDR into o_addr_rc and go to R_ADDR.
REQ-024 R_ADDR lasts one cycle: RDATA=i_data_rc (0 if invalid), RRESP=00 or 10, RVALID=1; then go to R_RESP.
REQ-025 R_RESP: RDATA, RRESP and RVALID SHALL be held until RREADY is sampled high; then RVALID=0 and the FSM returns to R_IDLE.
REQ-026 Read and write FSMs SHALL operate independently and concurrently; a same-cycle read of a location being written returns the pre-write value.
REQ-027 Control FSM SHALL have states C_IDLE, C_EXEC and C_DONE.
REQ-028 C_IDLE: o_is_busy=0; when i_start=1 at an edge, latch i_op into o_op and go to C_EXEC.
REQ-029 C_EXEC lasts exactly one cycle: o_is_busy=1, o_en_ctrl_write=1, o_rst_start=1.
REQ-030 C_DONE lasts exactly one cycle: o_is_busy=1 with strobes low; then return to C_IDLE.
REQ-031 o_op SHALL hold its last latched value between operations.
REQ-032 AXI outputs SHALL be registers or decodes of registered state only, with no combinational input-to-output path (exception: REQ-036).

Reset
REQ-033 ARSTn low SHALL put all FSMs in idle with BVALID=RVALID=WREADY=0, BRESP=RRESP=00, RDATA=0, all o_* outputs 0 and o_is_busy=0.
REQ-034 AWREADY and ARREADY SHALL be 1 in the first cycle after reset release.
REQ-035 Reset mid-transaction SHALL abandon the transaction without emitting any strobe.

Configuration
REQ-036 AXIL_BUSY_STALL_EN: when defined, AWREADY is forced to 0 while o_is_busy=1; when undefined, AWREADY ignores busy; reads are never stalled in either case.

Verification
REQ-037 Write 0x0000_aaaa to address 0 -> one-cycle o_en_amba_write, o_addr_wc=0, o_data_wc=0x0000_aaaa, o_strb=0xf, BRESP=00.
REQ-038 Write 0x3 to address 3, register-file model drives i_start=1 and i_op=1 -> o_op=1, o_is_busy high 2 cycles, o_en_ctrl_write and o_rst_start each a 1-cycle pulse.
REQ-039 With a register-file and adder model, write r0=0x0000_aaaa, r1=0xbbbb_0000, ctrl=0x3, then read address 2 -> RDATA=0xbbbb_aaaa, RRESP=00.
REQ-040 Write to address 5 -> BRESP=10 and no o_en_amba_write; read address 7 -> RRESP=10, RDATA=0.
REQ-041 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and payload stable; no new AW/AR accepted.
REQ-042 ARSTn low during W_DATA -> reset values and no strobe; the next write completes normally.
